baud_gen_frac: RTL and testbench
================================

BAUD_GEN_FRAC -- requirements
Module: baud_gen_frac

Interface
REQ-001 SHALL have parameter DIV_W, default 16: integer divisor width.
REQ-002 SHALL have parameter FRAC_W, default 4: fractional divisor width, in units of 1/2^FRAC_W.
REQ-003 SHALL have parameter OS_RATE, default 16: os_ticks per baud_tick, at least 2.
REQ-004 SHALL have parameter DEF_DIV, default 27: integer divisor after reset, at least 2.
REQ-005 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-007 SHALL have port en, input, 1 bit: count enable.
REQ-008 SHALL have port sync_clr, input, 1 bit: synchronous phase restart, used for start-bit alignment.
REQ-009 SHALL have port div_int, input, DIV_W bits: requested integer divisor.
REQ-010 SHALL have port div_frac, input, FRAC_W bits: requested fractional divisor.
REQ-011 SHALL have port div_load, input, 1 bit: one-cycle load strobe for div_int/div_frac.
REQ-012 SHALL have port os_tick, output, 1 bit: oversample tick, one-cycle pulse.
REQ-013 SHALL have port baud_tick, output, 1 bit: bit-rate tick, one-cycle pulse.
REQ-014 SHALL have port div_pending, output, 1 bit: shadow divisor waiting for a boundary.
REQ-015 SHALL have port cfg_err, output, 1 bit: one-cycle pulse on a rejected load.

Function
REQ-016 SHALL keep the following internal state:
- cnt: DIV_W+1 bits.
- period_cur: DIV_W+1 bits, equal to active integer divisor plus carry.
- acc: FRAC_W bits.
- os_cnt: ceil(log2(OS_RATE)) bits.
- active and shadow divisor registers.
REQ-017 SHALL define a boundary as a cycle with en=1, sync_clr=0 and cnt==period_cur-1.
REQ-018 On a boundary, SHALL register:
- cnt<=0 and os_tick<=1.
- acc<=(acc+frac_act) mod 2^FRAC_W.
- period_cur<=int_act+carry_out of that sum.
REQ-019 On a non-boundary cycle with en=1, SHALL register cnt<=cnt+1 and os_tick<=0.
REQ-020 With en=0, SHALL hold cnt, acc, os_cnt and period_cur, and drive os_tick=0 and baud_tick=0.
REQ-021 SHALL space os_ticks period_cur cycles apart, giving a long-run average of int_act+frac_act/2^FRAC_W cycles.
REQ-022 On a boundary with os_cnt==OS_RATE-1, SHALL register os_cnt<=0 and baud_tick<=1.
REQ-023 On any other boundary, SHALL register os_cnt<=os_cnt+1 and baud_tick<=0.
REQ-024 SHALL coincide each baud_tick with an os_tick.
REQ-025 On div_load with div_int>=2, SHALL register shadow<=(div_int,div_frac) and div_pending<=1.
REQ-026 A div_load that arrives while a load is already pending SHALL overwrite the shadow register.
REQ-027 On div_load with div_int<2, SHALL leave shadow and div_pending unchanged and pulse cfg_err for one cycle.
REQ-028 SHALL apply a pending shadow on a boundary, on a cycle with en=0, or on sync_clr, registering:
- active<=shadow, acc<=0 and period_cur<=shadow int.
- div_pending<=0.
The carry of that cycle SHALL be discarded.
REQ-029 A valid div_load coincident with an apply condition SHALL bypass the shadow register, take effect in the same cycle, and leave div_pending=0.
REQ-030 sync_clr SHALL take priority over a boundary, registering:
- cnt<=0, acc<=0 and os_cnt<=0.
- os_tick<=0 and baud_tick<=0.
- period_cur<=int_act, after any pending apply.
REQ-031 sync_clr SHALL act regardless of en.
REQ-032 Counters SHALL wrap only via the boundary rule and SHALL never exceed period_cur-1.

Reset
REQ-033 On rst_n=0, SHALL asynchronously set:
- cnt=0, acc=0 and os_cnt=0.
- os_tick=0, baud_tick=0, div_pending=0 and cfg_err=0.
- int_act=DEF_DIV, frac_act=0 and period_cur=DEF_DIV.
REQ-034 Reset asserted mid-period SHALL discard the partial count and any pending load.
REQ-035 After rst_n rises, the first os_tick SHALL occur DEF_DIV enabled cycles later.

Verification
REQ-036 SHALL cover: reset, then en=1 with DEF_DIV=27 and OS_RATE=16 -> os_tick every 27 cycles and baud_tick every 432 cycles.
REQ-037 SHALL cover: load div_int=4, div_frac=8 with en=0, then en=1 -> first os_tick after 4 cycles, then intervals 4,5,4,5...
REQ-038 SHALL cover: load div_int=10 mid-period -> div_pending=1 until the current os period ends, then intervals of 10.
REQ-039 SHALL cover: load div_int=1 -> one-cycle cfg_err, div_pending stays 0, tick spacing unchanged.
REQ-040 SHALL cover: sync_clr asserted on a boundary cycle -> no os_tick, cnt=0, os_cnt=0, next os_tick period_cur cycles later.
REQ-041 SHALL cover: en low for 7 cycles at cnt=3 -> ticks suppressed, counting resumes at cnt=4, os period stretched by exactly 7 cycles.

Source files
------------

// File: rtl/baud_gen_frac.sv
// rtl/baud_gen_frac.sv - fractional baud generator with oversample and bit-rate ticks
module baud_gen_frac #(
  parameter int DIV_W   = 16,
  parameter int FRAC_W  = 4,
  parameter int OS_RATE = 16,
  parameter int DEF_DIV = 27
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              sync_clr,
  input  logic [DIV_W-1:0]  div_int,
  input  logic [FRAC_W-1:0] div_frac,
  input  logic              div_load,
  output logic              os_tick,
  output logic              baud_tick,
  output logic              div_pending,
  output logic              cfg_err
);

  localparam int CNT_W = DIV_W + 1;
  localparam int OS_W  = (OS_RATE > 2) ? $clog2(OS_RATE) : 1;

  // phase state
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  r_period;
  logic [FRAC_W-1:0] r_acc;
  logic [OS_W-1:0]   r_os_cnt;
  logic              r_os_tick;
  logic              r_baud_tick;

  // divisor state: active pair drives the counters, shadow pair waits for a boundary
  logic [DIV_W-1:0]  r_int_act;
  logic [FRAC_W-1:0] r_frac_act;
  logic [DIV_W-1:0]  r_int_shd;
  logic [FRAC_W-1:0] r_frac_shd;
  logic              r_pending;
  logic              r_cfg_err;

  logic              w_load_ok;
  logic              w_boundary;
  logic              w_apply_cond;
  logic              w_apply;
  logic [DIV_W-1:0]  w_new_int;
  logic [FRAC_W-1:0] w_new_frac;
  logic [DIV_W-1:0]  w_int_nxt;
  logic [FRAC_W:0]   w_frac_sum;
  logic [CNT_W-1:0]  w_period_carry;
  logic              w_os_wrap;

  // A load is legal only when the integer divisor gives at least a two-cycle period.
  assign w_load_ok    = div_load && (div_int >= DIV_W'(2));
  assign w_boundary   = en && !sync_clr && (r_cnt == (r_period - CNT_W'(1)));
  // Divisor swaps happen only where they cannot tear a running period.
  assign w_apply_cond = w_boundary || !en || sync_clr;
  assign w_apply      = w_apply_cond && (w_load_ok || r_pending);
  // A fresh legal load at an apply point bypasses the shadow entirely.
  assign w_new_int    = w_load_ok ? div_int  : r_int_shd;
  assign w_new_frac   = w_load_ok ? div_frac : r_frac_shd;
  assign w_int_nxt    = w_apply ? w_new_int : r_int_act;

  assign w_frac_sum     = {1'b0, r_acc} + {1'b0, r_frac_act};
  assign w_period_carry = {1'b0, r_int_act} + {{DIV_W{1'b0}}, w_frac_sum[FRAC_W]};
  assign w_os_wrap      = (r_os_cnt == OS_W'(OS_RATE - 1));

  // divisor registers: shadow capture, apply to active, reject illegal loads
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_int_act  <= DIV_W'(DEF_DIV);
      r_frac_act <= '0;
      r_int_shd  <= DIV_W'(DEF_DIV);
      r_frac_shd <= '0;
      r_pending  <= 1'b0;
      r_cfg_err  <= 1'b0;
    end else begin
      r_cfg_err <= div_load && !w_load_ok;
      if (w_apply) begin
        r_int_act  <= w_new_int;
        r_frac_act <= w_new_frac;
        r_pending  <= 1'b0;
      end else if (w_load_ok) begin
        r_int_shd  <= div_int;
        r_frac_shd <= div_frac;
        r_pending  <= 1'b1;
      end
    end
  end

  // cycle counter, fractional accumulator and current period length
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_acc    <= '0;
      r_period <= CNT_W'(DEF_DIV);
    end else if (sync_clr) begin
      r_cnt    <= '0;
      r_acc    <= '0;
      r_period <= {1'b0, w_int_nxt};
    end else if (w_boundary) begin
      r_cnt <= '0;
      if (w_apply) begin
        // new divisor starts clean; this boundary's carry is dropped
        r_acc    <= '0;
        r_period <= {1'b0, w_new_int};
      end else begin
        r_acc    <= w_frac_sum[FRAC_W-1:0];
        r_period <= w_period_carry;
      end
    end else if (en) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end else if (w_apply) begin
      // paused swap: keep the held count unless the shorter period would strand it
      r_acc    <= '0;
      r_period <= {1'b0, w_new_int};
      if (r_cnt >= {1'b0, w_new_int}) begin
        r_cnt <= '0;
      end
    end
  end

  // oversample counter and the registered tick pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_os_cnt    <= '0;
      r_os_tick   <= 1'b0;
      r_baud_tick <= 1'b0;
    end else if (sync_clr) begin
      r_os_cnt    <= '0;
      r_os_tick   <= 1'b0;
      r_baud_tick <= 1'b0;
    end else if (w_boundary) begin
      r_os_tick <= 1'b1;
      if (w_os_wrap) begin
        r_os_cnt    <= '0;
        r_baud_tick <= 1'b1;
      end else begin
        r_os_cnt    <= r_os_cnt + OS_W'(1);
        r_baud_tick <= 1'b0;
      end
    end else begin
      r_os_tick   <= 1'b0;
      r_baud_tick <= 1'b0;
    end
  end

  assign os_tick     = r_os_tick;
  assign baud_tick   = r_baud_tick;
  assign div_pending = r_pending;
  assign cfg_err     = r_cfg_err;

endmodule

// File: tb/tb_baud_gen_frac.sv
// tb/tb_baud_gen_frac.sv - scoreboard bench for baud_gen_frac tick spacing and divisor loads
module tb_baud_gen_frac;

  localparam int DIV_W   = 16;
  localparam int FRAC_W  = 4;
  localparam int OS_RATE = 16;
  localparam int DEF_DIV = 27;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              en = 1'b0;
  logic              sync_clr = 1'b0;
  logic [DIV_W-1:0]  div_int = '0;
  logic [FRAC_W-1:0] div_frac = '0;
  logic              div_load = 1'b0;
  logic              os_tick;
  logic              baud_tick;
  logic              div_pending;
  logic              cfg_err;

  int n_vec = 0;
  int n_bad = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  baud_gen_frac #(
    .DIV_W(DIV_W), .FRAC_W(FRAC_W), .OS_RATE(OS_RATE), .DEF_DIV(DEF_DIV)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .sync_clr(sync_clr),
    .div_int(div_int), .div_frac(div_frac), .div_load(div_load),
    .os_tick(os_tick), .baud_tick(baud_tick),
    .div_pending(div_pending), .cfg_err(cfg_err)
  );

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // returns number of clock edges until os_tick is seen, or -1 on timeout
  task automatic wait_tick(input int bound, output int edges);
    int i;
    bit seen;
    edges = -1;
    seen = 1'b0;
    i = 0;
    while (!seen && i < bound) begin
      @(posedge clk);
      #1;
      i++;
      if (os_tick === 1'b1) begin
        seen = 1'b1;
        edges = i;
      end
    end
  endtask

  task automatic test_reset;
    step(2);
    n_vec++; if (os_tick !== 1'b0) begin n_bad++; $display("FAIL reset_os_tick: got %b want 0", os_tick); end
    n_vec++; if (baud_tick !== 1'b0) begin n_bad++; $display("FAIL reset_baud_tick: got %b want 0", baud_tick); end
    n_vec++; if (div_pending !== 1'b0) begin n_bad++; $display("FAIL reset_div_pending: got %b want 0", div_pending); end
    n_vec++; if (cfg_err !== 1'b0) begin n_bad++; $display("FAIL reset_cfg_err: got %b want 0", cfg_err); end
  endtask

  task automatic test_default;
    int n, e;
    logic eb;
    rst_n = 1'b1;
    en = 1'b1;
    for (int k = 0; k < 2 * OS_RATE; k++) exp_q.push_back(DEF_DIV);
    for (int k = 1; k <= 2 * OS_RATE; k++) begin
      wait_tick(100, n);
      e = exp_q.pop_front();
      n_vec++; if (n !== e) begin n_bad++; $display("FAIL default_interval[%0d]: got %0d want %0d", k, n, e); end
      eb = ((k % OS_RATE) == 0);
      n_vec++; if (baud_tick !== eb) begin n_bad++; $display("FAIL default_baud[%0d]: got %b want %b", k, baud_tick, eb); end
    end
  endtask

  task automatic test_frac;
    int n, e;
    en = 1'b0;
    sync_clr = 1'b1;
    step(1);
    sync_clr = 1'b0;
    div_load = 1'b1; div_int = 16'd4; div_frac = 4'd8;
    step(1);
    div_load = 1'b0;
    n_vec++; if (div_pending !== 1'b0) begin n_bad++; $display("FAIL frac_bypass_pending: got %b want 0", div_pending); end
    n_vec++; if (cfg_err !== 1'b0) begin n_bad++; $display("FAIL frac_cfg_err: got %b want 0", cfg_err); end
    en = 1'b1;
    exp_q.push_back(4); exp_q.push_back(4); exp_q.push_back(5); exp_q.push_back(4);
    exp_q.push_back(5); exp_q.push_back(4); exp_q.push_back(5); exp_q.push_back(4);
    for (int k = 1; k <= 8; k++) begin
      wait_tick(20, n);
      e = exp_q.pop_front();
      n_vec++; if (n !== e) begin n_bad++; $display("FAIL frac_interval[%0d]: got %0d want %0d", k, n, e); end
    end
  endtask

  task automatic test_pending;
    int n, e;
    step(2);
    div_load = 1'b1; div_int = 16'd10; div_frac = 4'd0;
    step(1);
    div_load = 1'b0;
    n_vec++; if (div_pending !== 1'b1) begin n_bad++; $display("FAIL pending_set: got %b want 1", div_pending); end
    exp_q.push_back(2);
    for (int k = 0; k < 3; k++) exp_q.push_back(10);
    wait_tick(20, n);
    e = exp_q.pop_front();
    n_vec++; if (n !== e) begin n_bad++; $display("FAIL pending_old_period_end: got %0d want %0d", n, e); end
    n_vec++; if (div_pending !== 1'b0) begin n_bad++; $display("FAIL pending_cleared: got %b want 0", div_pending); end
    for (int k = 1; k <= 3; k++) begin
      wait_tick(30, n);
      e = exp_q.pop_front();
      n_vec++; if (n !== e) begin n_bad++; $display("FAIL pending_interval[%0d]: got %0d want %0d", k, n, e); end
    end
  endtask

  task automatic test_cfg_err;
    int n, e;
    step(3);
    div_load = 1'b1; div_int = 16'd1; div_frac = 4'd3;
    step(1);
    div_load = 1'b0;
    n_vec++; if (cfg_err !== 1'b1) begin n_bad++; $display("FAIL cfg_err_pulse: got %b want 1", cfg_err); end
    n_vec++; if (div_pending !== 1'b0) begin n_bad++; $display("FAIL cfg_err_pending: got %b want 0", div_pending); end
    step(1);
    n_vec++; if (cfg_err !== 1'b0) begin n_bad++; $display("FAIL cfg_err_one_cycle: got %b want 0", cfg_err); end
    exp_q.push_back(5); exp_q.push_back(10); exp_q.push_back(10);
    for (int k = 1; k <= 3; k++) begin
      wait_tick(30, n);
      e = exp_q.pop_front();
      n_vec++; if (n !== e) begin n_bad++; $display("FAIL cfg_err_interval[%0d]: got %0d want %0d", k, n, e); end
    end
  endtask

  task automatic test_sync_clr;
    int n, e;
    logic eb;
    step(9);
    sync_clr = 1'b1;
    step(1);
    sync_clr = 1'b0;
    n_vec++; if (os_tick !== 1'b0) begin n_bad++; $display("FAIL sync_clr_no_tick: got %b want 0", os_tick); end
    n_vec++; if (baud_tick !== 1'b0) begin n_bad++; $display("FAIL sync_clr_no_baud: got %b want 0", baud_tick); end
    for (int k = 0; k < OS_RATE; k++) exp_q.push_back(10);
    for (int k = 1; k <= OS_RATE; k++) begin
      wait_tick(30, n);
      e = exp_q.pop_front();
      n_vec++; if (n !== e) begin n_bad++; $display("FAIL sync_clr_interval[%0d]: got %0d want %0d", k, n, e); end
      eb = (k == OS_RATE);
      n_vec++; if (baud_tick !== eb) begin n_bad++; $display("FAIL sync_clr_baud[%0d]: got %b want %b", k, baud_tick, eb); end
    end
  endtask

  task automatic test_en_hold;
    int n, e;
    step(3);
    en = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      step(1);
      n_vec++; if (os_tick !== 1'b0) begin n_bad++; $display("FAIL en_hold_os_tick[%0d]: got %b want 0", k, os_tick); end
    end
    en = 1'b1;
    exp_q.push_back(7); exp_q.push_back(10);
    for (int k = 1; k <= 2; k++) begin
      wait_tick(30, n);
      e = exp_q.pop_front();
      n_vec++; if (n !== e) begin n_bad++; $display("FAIL en_hold_interval[%0d]: got %0d want %0d", k, n, e); end
    end
  endtask

  task automatic test_back_to_back;
    int n, e;
    div_load = 1'b1; div_int = 16'd6; div_frac = 4'd0;
    step(1);
    div_int = 16'd12;
    step(1);
    div_load = 1'b0;
    n_vec++; if (div_pending !== 1'b1) begin n_bad++; $display("FAIL b2b_pending: got %b want 1", div_pending); end
    exp_q.push_back(8); exp_q.push_back(12); exp_q.push_back(12);
    for (int k = 1; k <= 3; k++) begin
      wait_tick(30, n);
      e = exp_q.pop_front();
      n_vec++; if (n !== e) begin n_bad++; $display("FAIL b2b_interval[%0d]: got %0d want %0d", k, n, e); end
    end
  endtask

  task automatic test_reset_mid;
    int n, e;
    step(5);
    div_load = 1'b1; div_int = 16'd6; div_frac = 4'd0;
    step(1);
    div_load = 1'b0;
    n_vec++; if (div_pending !== 1'b1) begin n_bad++; $display("FAIL rst_mid_pending_pre: got %b want 1", div_pending); end
    rst_n = 1'b0;
    #1;
    n_vec++; if (div_pending !== 1'b0) begin n_bad++; $display("FAIL rst_mid_pending_async: got %b want 0", div_pending); end
    step(2);
    rst_n = 1'b1;
    exp_q.push_back(DEF_DIV); exp_q.push_back(DEF_DIV);
    for (int k = 1; k <= 2; k++) begin
      wait_tick(60, n);
      e = exp_q.pop_front();
      n_vec++; if (n !== e) begin n_bad++; $display("FAIL rst_mid_interval[%0d]: got %0d want %0d", k, n, e); end
    end
  endtask

  initial begin
    test_reset();
    test_default();
    test_frac();
    test_pending();
    test_cfg_err();
    test_sync_clr();
    test_en_hold();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
